// File: rtl/arbiter_rr_encoded_if.sv
// Grant handshake bundle between the round-robin arbiter and its consumer.
interface arbiter_rr_encoded_if #(
    parameter int unsigned M = 4,
    parameter int unsigned N = 2**M
);
    logic [N-1:0] i_req;
    logic         i_gnt_ack;
    logic         o_gnt_valid;
    logic [M-1:0] o_gnt_id;

    // Arbiter side: consumes requests/ack, produces the encoded grant.
    modport master (
        input  i_req,
        input  i_gnt_ack,
        output o_gnt_valid,
        output o_gnt_id
    );

    // Requester/consumer side.
    modport slave (
        output i_req,
        output i_gnt_ack,
        input  o_gnt_valid,
        input  o_gnt_id
    );
endinterface

// File: rtl/arbiter_rr_encoded.sv
// Round-robin arbiter with a registered binary-encoded grant under valid/ack.
// The acknowledged requester drops to lowest priority; the grant is held
// stable (never retracted) until the consumer acknowledges it.
module arbiter_rr_encoded #(
    parameter int unsigned M = 4,
    parameter int unsigned N = 2**M
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    arbiter_rr_encoded_if.master  bus
);
    localparam logic [M-1:0] LAST_ID = M'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t       state;
    logic [M-1:0] ptr;
    logic [M-1:0] gnt_id;

    logic         handshake;
    logic         load;
    logic [M-1:0] next_id;
    logic [M-1:0] ptr_eff;
    logic [M-1:0] winner;
    logic [M-1:0] idx;
    logic         any_req;

    // Handshake frees the current grant; a new one may be loaded on the same edge.
    assign handshake = (state == GRANT) && bus.i_gnt_ack;
    assign load      = (state == IDLE) || handshake;
    assign next_id   = (gnt_id == LAST_ID) ? '0 : gnt_id + M'(1);
    assign ptr_eff   = handshake ? next_id : ptr;

    // Cyclic priority search starting at ptr_eff, wrapping at N (not 2**M).
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = M'((32'(ptr_eff) + k) % N);
            if (!any_req && bus.i_req[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

    // Grant FSM, rotating pointer and registered grant index.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt_id <= '0;
        end else begin
            if (handshake) begin
                ptr <= next_id;
            end
            if (load) begin
                if (any_req) begin
                    gnt_id <= winner;
                    state  <= GRANT;
                end else begin
                    state  <= IDLE;
                end
            end
        end
    end

    // Outputs come straight from flops: 1-bit state encoding and gnt_id.
    assign bus.o_gnt_valid = (state == GRANT);
    assign bus.o_gnt_id    = gnt_id;

endmodule

// File: tb/tb_arbiter_rr_encoded.sv
// Scoreboard bench for arbiter_rr_encoded: three instances (N=4, N=3, N=16)
// checked against a priority-list reference model.
module tb_arbiter_rr_encoded;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    arbiter_rr_encoded_if #(.M(2), .N(4))  bus0 ();
    arbiter_rr_encoded_if #(.M(2), .N(3))  bus1 ();
    arbiter_rr_encoded_if #(.M(4), .N(16)) bus2 ();

    arbiter_rr_encoded #(.M(2), .N(4))  dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
    arbiter_rr_encoded #(.M(2), .N(3))  dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));
    arbiter_rr_encoded #(.M(4), .N(16)) dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus2));

    logic [15:0] req [3];
    logic        ack [3];
    logic        vld [3];
    logic [3:0]  gid [3];

    assign bus0.i_req     = req[0][3:0];
    assign bus1.i_req     = req[1][2:0];
    assign bus2.i_req     = req[2];
    assign bus0.i_gnt_ack = ack[0];
    assign bus1.i_gnt_ack = ack[1];
    assign bus2.i_gnt_ack = ack[2];
    assign vld[0] = bus0.o_gnt_valid;
    assign vld[1] = bus1.o_gnt_valid;
    assign vld[2] = bus2.o_gnt_valid;
    assign gid[0] = 4'(bus0.o_gnt_id);
    assign gid[1] = 4'(bus1.o_gnt_id);
    assign gid[2] = 4'(bus2.o_gnt_id);

    int total = 0;
    int bad   = 0;

    function automatic int nof(int d);
        case (d)
            0:       return 4;
            1:       return 3;
            default: return 16;
        endcase
    endfunction

    task automatic check(string name, int act, int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each instance keeps an explicit priority list (highest first). A
    // handshake rotates the list so the acked id sits at the tail.
    int ord [3][16];
    int cur [3];
    bit mv  [3];
    int q0 [$];
    int q1 [$];
    int q2 [$];

    function automatic void push(int d, int id);
        case (d)
            0:       q0.push_back(id);
            1:       q1.push_back(id);
            default: q2.push_back(id);
        endcase
    endfunction

    task automatic pop(input int d, output int id, output bit ok);
        ok = 1'b0;
        id = 0;
        case (d)
            0:       if (q0.size() > 0) begin id = q0.pop_front(); ok = 1'b1; end
            1:       if (q1.size() > 0) begin id = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin id = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 16; k++) ord[d][k] = k;
            cur[d] = 0;
            mv[d]  = 1'b0;
        end
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    task automatic model_step(int d);
        int n;
        int first;
        bit hs;
        n  = nof(d);
        hs = mv[d] && (ack[d] === 1'b1);
        if (hs) begin
            while (ord[d][n-1] != cur[d]) begin
                first = ord[d][0];
                for (int k = 0; k < n - 1; k++) ord[d][k] = ord[d][k+1];
                ord[d][n-1] = first;
            end
        end
        if (!mv[d] || hs) begin
            mv[d] = 1'b0;
            for (int k = 0; k < n; k++) begin
                if (!mv[d] && req[d][4'(ord[d][k])]) begin
                    mv[d]  = 1'b1;
                    cur[d] = ord[d][k];
                    push(d, cur[d]);
                end
            end
        end
    endtask

    // Model advances on the same edges as the DUTs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else for (int d = 0; d < 3; d++) model_step(d);
    end

    // ---------------- monitor ----------------
    bit         pv [3];
    bit         pa [3];
    logic [3:0] pid [3];
    bit         fair_on;
    int         fair_cnt [16];
    int         fair_hs;
    int         mon_id;
    bit         mon_ok;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                pv[d] = 1'b0; pa[d] = 1'b0; pid[d] = '0;
            end
            fair_hs = 0;
            for (int k = 0; k < 16; k++) fair_cnt[k] = 0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                check($sformatf("valid%0d", d), int'(vld[d]), int'(mv[d]));
                if (vld[d] && (!pv[d] || pa[d])) begin
                    pop(d, mon_id, mon_ok);
                    if (!mon_ok) begin
                        total++;
                        bad++;
                        $display("FAIL pop%0d: grant id %0d shown, no grant expected at %0t", d, gid[d], $time);
                    end else begin
                        check($sformatf("grant_id%0d", d), int'(gid[d]), mon_id);
                    end
                end else if (vld[d] && pv[d]) begin
                    check($sformatf("hold_id%0d", d), int'(gid[d]), int'(pid[d]));
                end
                if (d == 2 && fair_on && vld[2] && ack[2]) begin
                    fair_cnt[gid[2]]++;
                    fair_hs++;
                    if (fair_hs == 16) begin
                        for (int k = 0; k < 16; k++) begin
                            check($sformatf("fair_id%0d", k), fair_cnt[k], 1);
                            fair_cnt[k] = 0;
                        end
                        fair_hs = 0;
                    end
                end
                pv[d]  = vld[d];
                pa[d]  = ack[d];
                pid[d] = gid[d];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        fair_on = 1'b0;
        for (int d = 0; d < 3; d++) begin
            req[d] = '0;
            ack[d] = 1'b0;
        end
        tick(3);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_valid%0d", d), int'(vld[d]), 0);
            check($sformatf("rst_id%0d", d), int'(gid[d]), 0);
        end
        rst_n = 1'b1;

        // Rotation with ack held: 0,1,2,3,0,...
        req[0] = 16'hF;
        ack[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("rot_valid", int'(vld[0]), 1);
            check("rot_id", int'(gid[0]), i % 4);
        end
        req[0] = '0;
        tick(1);
        check("rot_drain_valid", int'(vld[0]), 0);
        ack[0] = 1'b0;

        // Hold without ack, request dropped.
        req[0] = 16'h2;
        tick(1);
        req[0] = '0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("hold_valid", int'(vld[0]), 1);
            check("hold_id", int'(gid[0]), 1);
        end
        ack[0] = 1'b1;
        tick(1);
        check("hold_ack_valid", int'(vld[0]), 0);
        ack[0] = 1'b0;
        req[0] = 16'hF;
        tick(1);
        check("ptr_after_hold", int'(gid[0]), 2);

        // Wrap and skip.
        req[0] = 16'h8;
        ack[0] = 1'b1;
        tick(1);
        check("wrap_id3", int'(gid[0]), 3);
        req[0] = 16'h5;
        tick(1);
        check("wrap_id0", int'(gid[0]), 0);
        tick(1);
        check("skip_id2", int'(gid[0]), 2);
        req[0] = '0;
        tick(1);
        ack[0] = 1'b0;

        // Reset in the middle of a grant.
        req[0] = 16'h4;
        tick(1);
        check("pre_rst_id", int'(gid[0]), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(vld[0]), 0);
        check("mid_rst_id", int'(gid[0]), 0);
        #3;
        rst_n = 1'b1;
        tick(1);
        check("post_rst_valid", int'(vld[0]), 1);
        check("post_rst_id", int'(gid[0]), 2);
        req[0] = '0;
        ack[0] = 1'b1;
        tick(1);
        ack[0] = 1'b0;

        // Non-power-of-two N=3.
        req[1] = 16'h7;
        ack[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("n3_id", int'(gid[1]), i % 3);
        end
        req[1] = '0;
        tick(1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("spurious_ack_valid", int'(vld[1]), 0);
        end
        ack[1] = 1'b0;
        req[1] = 16'h3;
        tick(1);
        check("n3_ptr_kept", int'(gid[1]), 0);
        req[1] = '0;
        ack[1] = 1'b1;
        tick(1);
        ack[1] = 1'b0;

        // Fairness on N=16 with all requests and random ack.
        req[2] = 16'hFFFF;
        tick(1);
        fair_on = 1'b1;
        for (int i = 0; i < 320; i++) begin
            ack[2] = 1'($urandom_range(0, 1));
            tick(1);
        end
        fair_on = 1'b0;

        // Random traffic on all instances.
        for (int i = 0; i < 500; i++) begin
            for (int d = 0; d < 3; d++) begin
                req[d] = 16'($urandom) & 16'((32'd1 << nof(d)) - 1);
                ack[d] = 1'($urandom_range(0, 1));
            end
            tick(1);
        end

        // Drain and confirm every expected grant was observed.
        for (int d = 0; d < 3; d++) begin
            req[d] = '0;
            ack[d] = 1'b1;
        end
        tick(4);
        for (int d = 0; d < 3; d++) ack[d] = 1'b0;
        tick(2);
        check("q0_left", q0.size(), 0);
        check("q1_left", q1.size(), 0);
        check("q2_left", q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/arbiter_rr_encoded.md
# arbiter_rr_encoded

Round-robin arbiter that picks one of N requesters and presents the winner as an M-bit binary index under a valid/ack handshake. It sits directly upstream of the binary-to-one-hot decoder: `o_gnt_id` drives the decoder's encoded input, and the decoder's one-hot output selects the granted requester. The grant is registered and held stable until it is acknowledged. Priority rotates so the most recently acknowledged requester becomes lowest priority.

## Interface
- `M`, default 4: width of the encoded grant index.
- `N`, default 2**M: number of requesters. Legal range is 2..2**M.
- `i_clk`  input  1: clock. All state updates on the rising edge.
- `i_rst_n`  input  1: reset, asynchronous and active-low.
- `i_req`  input  N: request vector; bit k means requester k wants a grant. Level-sensitive.
- `i_gnt_ack`  input  1: consumer accepts the current grant. Meaningful only while `o_gnt_valid`=1.
- `o_gnt_valid`  output  1: `o_gnt_id` holds a valid grant.
- `o_gnt_id`  output  M: binary index of the granted requester.

## Operation
- State machine:
  - IDLE: `o_gnt_valid`=0.
  - GRANT: `o_gnt_valid`=1, grant waiting for ack.
- Registers:
  - `ptr` (M bits): highest-priority requester.
  - `gnt_id` (M bits): current grant index.
  - `state`.
- Arbitration is combinational, from `ptr_eff` and `i_req`:
  - Winner = first index k with `i_req[k]`=1, searching `ptr_eff`, `ptr_eff`+1, … N-1, 0, … `ptr_eff`-1.
  - `ptr_eff` = (`gnt_id`+1) mod N if `o_gnt_valid` & `i_gnt_ack`, else `ptr`.
- Load condition: (state==IDLE) or (`o_gnt_valid` & `i_gnt_ack`).
  - Load and any request: `gnt_id` <= winner, state <= GRANT.
  - Load and no request: state <= IDLE, `gnt_id` unchanged.
- On every handshake (`o_gnt_valid` & `i_gnt_ack`): `ptr` <= (`gnt_id`+1) mod N. Wrap: `gnt_id`=N-1 gives `ptr`=0, including non-power-of-two N.
- In GRANT without ack:
  - `o_gnt_id` and `o_gnt_valid` hold.
  - A deasserted `i_req[gnt_id]` does not retract the grant (no retraction rule).
  - New requests are ignored until the handshake.
- `i_gnt_ack` while `o_gnt_valid`=0 is ignored.
- Request bits with index ≥ N do not exist. Indices N..2**M-1 are never produced on `o_gnt_id`.
- The acked requester may keep `i_req` high. It re-enters arbitration at lowest priority in the same cycle.

## Timing
- Reset (async assert, any cycle, including mid-grant): state=IDLE, `o_gnt_valid`=0, `o_gnt_id`=0, `ptr`=0.
- First load is allowed on the first rising edge after `i_rst_n` deasserts.
- Latency: request seen on edge t while IDLE gives `o_gnt_valid`=1 after edge t, i.e. visible in cycle t+1.
- Back-to-back throughput: with ack held high and requests pending, one new grant per cycle. `o_gnt_valid` stays 1 continuously.
- Handshake with no pending requests: `o_gnt_valid`=0 in the following cycle.
- Outputs are registered. No combinational path from `i_req` or `i_gnt_ack` to any output.
- Simultaneous handshake and new request:
  - The new request participates, using `ptr_eff` = `gnt_id`+1.
  - The pointer update and the new grant take effect on the same edge.

## Test plan
Use M=2, N=4 unless stated.
- **Reset mid-grant:** assert `i_rst_n`=0 while `o_gnt_valid`=1, `o_gnt_id`=2 → outputs go to valid=0, id=0 immediately, without a clock edge. After release with `i_req`=4'b0100 → valid=1, id=2 one cycle later.
- **Rotation:** `i_req`=4'b1111 and `i_gnt_ack`=1 held → `o_gnt_id` sequence 0,1,2,3,0,1… one per cycle, valid never drops.
- **Hold without ack:** `i_req`=4'b0010, ack=0, then drop `i_req` to 0 → id=1 and valid=1 hold for 10 cycles. On ack → valid=0 next cycle, `ptr`=2.
- **Wrap and skip:** after an ack of id=3, `i_req`=4'b0101 → next grant id=0. After acking that, `i_req`=4'b0101 → id=2.
- **Non-power-of-two N:** M=2, N=3, `i_req`=3'b111, ack held → ids 0,1,2,0. Id 3 is never observed. Spurious ack while valid=0 → no state change.
- **Fairness:** M=4, N=16, all requests high, ack random at 50% → each id granted exactly once per 16 handshakes. `o_gnt_id` is stable whenever valid=1 and ack=0.
